lose_anim_ctrl: RTL and testbench
=================================

// Module: lose_anim_ctrl
// PURPOSE
//  Drives the lose-sprite placement (lose_x, lose_y) consumed by the 256x256 lose sprite display stage.
//  On game over, the sprite rises from below the visible area to screen centre.
//  It then shakes horizontally for a fixed number of frames and settles.
//  Position changes only on frame_tick (vblank), so the display never tears mid-frame.
// PARAMETERS
//  H_ACTIVE      800  visible width in pixels
//  V_ACTIVE      600  visible height in lines; also the sprite start Y (fully off-screen)
//  SPRITE_SZ     256  sprite edge length in pixels
//  RISE_STEP     8    pixels lose_y decreases per frame in RISE
//  SHAKE_AMP     4    horizontal shake offset in pixels
//  SHAKE_FRAMES  16   number of frames spent in SHAKE
// PORTS
//  clk          in   1   system/pixel clock; the only clock in the block
//  reset        in   1   asynchronous, active-high reset
//  frame_tick   in   1   one-cycle pulse per frame, at vblank start, from vga_sync
//  game_over    in   1   level signal from game logic; a rising edge starts the animation
//  restart      in   1   one-cycle pulse that returns the block to IDLE
//  lose_x       out  11  sprite left X; registered
//  lose_y       out  10  sprite top Y; registered
//  lose_visible out  1   qualifies lose_on downstream; high in RISE, SHAKE and SHOW
//  anim_done    out  1   high only in SHOW
// BEHAVIOUR
//  Constants: CX = (H_ACTIVE-SPRITE_SZ)/2 = 272; TY = (V_ACTIVE-SPRITE_SZ)/2 = 172.
//  Reset (async, any state):
//   - state=IDLE, lose_x=CX, lose_y=V_ACTIVE
//   - lose_visible=0, anim_done=0, shake_cnt=0, game_over_q=0
//  Edge detect: game_over_q registers game_over; go_rise = game_over & ~game_over_q.
//  All outputs are registered; every update appears 1 clk after the causing input.
//  FSM:
//   - IDLE:  go_rise -> RISE; lose_y=V_ACTIVE, lose_x=CX, lose_visible=1. The trigger does not need frame_tick.
//   - RISE:  on frame_tick, if lose_y-RISE_STEP <= TY: lose_y=TY, shake_cnt=0, go to SHAKE.
//            Otherwise lose_y -= RISE_STEP. Compare in 11 bits; no underflow is possible.
//   - SHAKE: on frame_tick, lose_x = CX+SHAKE_AMP when shake_cnt is even, CX-SHAKE_AMP when odd, then shake_cnt++.
//            On the tick where shake_cnt==SHAKE_FRAMES-1: lose_x=CX, go to SHOW.
//   - SHOW:  lose_x=CX, lose_y=TY, anim_done=1. Holds until restart.
//  restart (any state except IDLE): go to IDLE with the same output values as reset. No effect in IDLE.
//  Priority: reset > restart > go_rise > frame_tick.
//   - restart and frame_tick in the same cycle: restart wins and the tick is discarded.
//  go_rise outside IDLE is ignored.
//   - restart while game_over is still high does not retrigger; a new rising edge is required.
//  frame_tick in IDLE or SHOW has no effect.
//  shake_cnt is ceil(log2(SHAKE_FRAMES+1)) bits wide and saturates; it never wraps.
//  Reset mid-animation is handled like power-up reset: no partial position is held.
// STRUCTURE
//  Package lose_anim_pkg:
//   - state enum {IDLE, RISE, SHAKE, SHOW} (2 bits)
//   - CX/TY derivation functions
//   - default screen and sprite constants, shared with the lose display and the top level
//  Sub-module rise_edge_det (1-bit registered edge detector, async active-high reset) for game_over.
//  Everything else is a single always block for FSM plus datapath, with one output register set.
// TESTING
//  1. Reset asserted mid-RISE (lose_y=400) -> next cycle: lose_y=600, lose_x=272, lose_visible=0, state IDLE.
//  2. game_over 0->1, then 54 frame_ticks -> lose_y=592 after tick 1, 176 after tick 53, clamped to 172 on tick 54.
//     State becomes SHAKE at tick 54.
//  3. SHAKE, 16 ticks -> lose_x sequence 276, 268, ... (alternating, 15 values).
//     On tick 16: lose_x=272, anim_done=1, lose_visible=1.
//  4. restart and frame_tick in the same cycle during RISE -> IDLE next cycle, lose_y=600, lose_visible=0.
//     game_over held high afterwards -> stays in IDLE.
//  5. game_over toggled 1->0->1 during SHAKE -> ignored; shake sequence and final SHOW timing unchanged.
//  6. No frame_tick for 1000 cycles in RISE -> lose_y constant; outputs change only the cycle after a tick.

Source files
------------

// File: rtl/lose_anim_pkg.sv
// lose_anim_pkg: screen/sprite constants, FSM state type and placement helpers for the lose animation
package lose_anim_pkg;
  localparam int H_ACTIVE     = 800;
  localparam int V_ACTIVE     = 600;
  localparam int SPRITE_SZ    = 256;
  localparam int RISE_STEP    = 8;
  localparam int SHAKE_AMP    = 4;
  localparam int SHAKE_FRAMES = 16;
  localparam int CNT_W        = $clog2(SHAKE_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, RISE, SHAKE, SHOW} state_t;
  function automatic int center(input int span, input int sz);
    return (span - sz) / 2;
  endfunction
  localparam int CX = center(H_ACTIVE, SPRITE_SZ);
  localparam int TY = center(V_ACTIVE, SPRITE_SZ);
endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det: registered rising-edge detector with async active-high reset
module rise_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic d_q;
  // remember last cycle's level
  always_ff @(posedge clk or posedge reset)
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/lose_anim_ctrl.sv
// lose_anim_ctrl: rise, shake and settle animation of the lose sprite, updated only on frame ticks
module lose_anim_ctrl
  import lose_anim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        game_over,
  input  logic        restart,
  output logic [10:0] lose_x,
  output logic [9:0]  lose_y,
  output logic        lose_visible,
  output logic        anim_done
);
  localparam logic [10:0] CX_X     = 11'(CX);
  localparam logic [9:0]  TY_Y     = 10'(TY);
  localparam logic [9:0]  START_Y  = 10'(V_ACTIVE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHAKE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(SHAKE_FRAMES);
  state_t           state_q, state_d;
  logic [10:0]      x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             vis_q, vis_d, done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_rise;
  logic [10:0]      y_dec;
  rise_edge_det u_go (.clk(clk), .reset(reset), .d(game_over), .rise(go_rise));
  assign y_dec = {1'b0, y_q} - 11'(RISE_STEP);
  // next state and next output values; restart beats trigger, trigger beats tick
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    if (restart && state_q != IDLE) begin
      state_d = IDLE;
      x_d     = CX_X;
      y_d     = START_Y;
      vis_d   = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (go_rise) begin
          state_d = RISE;
          x_d     = CX_X;
          y_d     = START_Y;
          vis_d   = 1'b1;
        end
        RISE: if (frame_tick) begin
          if (y_dec <= 11'(TY)) begin
            state_d = SHAKE;
            y_d     = TY_Y;
            cnt_d   = '0;
          end else y_d = y_dec[9:0];
        end
        SHAKE: if (frame_tick) begin
          cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = SHOW;
            x_d     = CX_X;
            done_d  = 1'b1;
          end else x_d = cnt_q[0] ? CX_X - 11'(SHAKE_AMP) : CX_X + 11'(SHAKE_AMP);
        end
        default: begin
          x_d    = CX_X;
          y_d    = TY_Y;
          done_d = 1'b1;
        end
      endcase
    end
  end
  // single output/state register set
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      x_q     <= CX_X;
      y_q     <= START_Y;
      vis_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  assign lose_x       = x_q;
  assign lose_y       = y_q;
  assign lose_visible = vis_q;
  assign anim_done    = done_q;
endmodule

// File: tb/tb_lose_anim_ctrl.sv
// tb_lose_anim_ctrl: directed and randomized checks of lose_anim_ctrl against a tick-count model
module tb_lose_anim_ctrl;
  logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, game_over = 1'b0, restart = 1'b0;
  logic [10:0] lose_x;
  logic [9:0]  lose_y;
  logic        lose_visible, anim_done;
  int checks = 0, errors = 0;
  lose_anim_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .game_over(game_over),
    .restart(restart), .lose_x(lose_x), .lose_y(lose_y),
    .lose_visible(lose_visible), .anim_done(anim_done)
  );
  always #5 clk = ~clk;
  // model: the animation is fully described by whether it runs and how many ticks it has seen
  localparam int SX = 272, SY0 = 600, TYE = 172, STEP = 8, AMP = 4, NSHAKE = 16;
  localparam int NRISE = (SY0 - TYE + STEP - 1) / STEP;
  bit m_act = 0, m_go = 0;
  int m_ticks = 0;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_act = 0; m_ticks = 0; m_go = 0;
    end else begin
      if (restart && m_act) begin
        m_act = 0; m_ticks = 0;
      end else if (!m_act && game_over && !m_go) begin
        m_act = 1; m_ticks = 0;
      end else if (m_act && frame_tick && m_ticks < NRISE + NSHAKE) m_ticks++;
      m_go = game_over;
    end
  always @(negedge clk) begin
    int ex, ey, s;
    bit ev, ed;
    s  = m_ticks - NRISE;
    ev = m_act;
    ed = m_act && s >= NSHAKE;
    ey = (!m_act || m_ticks < NRISE) ? SY0 - (m_act ? STEP * m_ticks : 0) : TYE;
    ex = (m_act && s >= 1 && s < NSHAKE) ? ((s % 2 == 1) ? SX + AMP : SX - AMP) : SX;
    checks++;
    if (int'(lose_x) != ex || int'(lose_y) != ey || lose_visible !== ev || anim_done !== ed) begin
      errors++;
      $display("FAIL model @%0t: x=%0d y=%0d vis=%0b done=%0b expected x=%0d y=%0d vis=%0b done=%0b",
               $time, lose_x, lose_y, lose_visible, anim_done, ex, ey, ev, ed);
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
    end
  endtask
  initial begin
    #1 reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("reset_x", lose_x, 272); chk("reset_y", lose_y, 600);
    chk("reset_vis", lose_visible, 0); chk("reset_done", anim_done, 0);
    game_over = 1'b1;
    step(1);
    chk("trig_vis", lose_visible, 1); chk("trig_y", lose_y, 600);
    tick(1);  chk("rise_t1", lose_y, 592);
    tick(52); chk("rise_t53", lose_y, 176);
    tick(1);  chk("rise_clamp", lose_y, 172);
    tick(1);  chk("shake_1", lose_x, 276);
    game_over = 1'b0;
    tick(1);  chk("shake_2", lose_x, 268);
    game_over = 1'b1;
    tick(13); chk("shake_15", lose_x, 276); chk("shake_15_done", anim_done, 0);
    tick(1);  chk("show_x", lose_x, 272); chk("show_done", anim_done, 1); chk("show_vis", lose_visible, 1);
    tick(3);  chk("show_hold_y", lose_y, 172);
    restart = 1'b1; step(1); restart = 1'b0;
    chk("restart_vis", lose_visible, 0); chk("restart_done", anim_done, 0);
    tick(3); step(5);
    chk("no_retrigger_vis", lose_visible, 0); chk("no_retrigger_y", lose_y, 600);
    game_over = 1'b0; step(1); game_over = 1'b1; step(1);
    tick(5); chk("rise2_y", lose_y, 560);
    step(1000); chk("idle_ticks_y", lose_y, 560);
    restart = 1'b1; frame_tick = 1'b1; step(1); restart = 1'b0; frame_tick = 1'b0;
    chk("restart_tick_y", lose_y, 600); chk("restart_tick_vis", lose_visible, 0);
    game_over = 1'b0; step(1); game_over = 1'b1; step(1);
    tick(25); chk("mid_rise_y", lose_y, 400);
    reset = 1'b1; #1;
    chk("async_rst_y", lose_y, 600); chk("async_rst_x", lose_x, 272); chk("async_rst_vis", lose_visible, 0);
    step(1); reset = 1'b0; game_over = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      reset      = ($urandom_range(0, 2999) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      restart    = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 59) == 0) game_over = ~game_over;
      step(1);
    end
    reset = 1'b0; frame_tick = 1'b0; restart = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
